// File: rtl/host_cmd_decoder_pkg.sv
// Shared definitions for the host command decoder: word indices, default tags,
// FSM state encoding and the expected-header packing helper.
package host_cmd_decoder_pkg;

    localparam int HDR_W0 = 0;
    localparam int HDR_W1 = 1;
    localparam int HDR_W2 = 2;
    localparam int HDR_W3 = 3;
    localparam int TAG_W4 = 4;
    localparam int ARG_W5 = 5;

    localparam logic [47:0] TRIG_TAG = 48'h6e69_6769_7274;
    localparam logic [47:0] SLOW_TAG = 48'h656d_776f_6c73;
    localparam logic [47:0] RATE_TAG = 48'h6e69_6574_6172;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_TAG,
        ST_ARG,
        ST_WAITLAST,
        ST_DISCARD
    } state_t;

    typedef logic [4:0][31:0] hdr_words_t;

    function automatic hdr_words_t pack_hdr_words(
        input logic [47:0] dst,
        input logic [47:0] src,
        input logic [15:0] eth,
        input logic [47:0] tag
    );
        hdr_words_t w;
        w[HDR_W0] = dst[31:0];
        w[HDR_W1] = {src[15:0], dst[47:32]};
        w[HDR_W2] = src[47:16];
        w[HDR_W3] = {tag[15:0], eth};
        w[TAG_W4] = tag[47:16];
        return w;
    endfunction

endpackage

// File: rtl/host_cmd_tagmatch.sv
// Combinational priority matcher of a 48-bit tag against the command table;
// the lowest matching index wins.
module host_cmd_tagmatch #(
    parameter int                     NUM_CMDS = 3,
    parameter logic [NUM_CMDS*48-1:0] CMD_TAGS = '0,
    parameter int                     ID_W     = 2
) (
    input  logic [47:0]     tag,
    output logic            hit,
    output logic [ID_W-1:0] id
);

    logic [NUM_CMDS-1:0] eq;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CMDS; gi++) begin : g_cmp
            assign eq[gi] = (tag == CMD_TAGS[48*gi +: 48]);
        end
    endgenerate

    // Walk downwards so the lowest matching entry is the one left standing.
    always_comb begin
        hit = 1'b0;
        id  = '0;
        for (int i = NUM_CMDS - 1; i >= 0; i--) begin
            if (eq[i]) begin
                hit = 1'b1;
                id  = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/host_cmd_decoder.sv
// Parses host-to-FPGA control frames from the MAC RX stream and emits one decoded
// command per good frame. Define HOSTCMD_STATS_EN to build the frame/drop counters.
module host_cmd_decoder
    import host_cmd_decoder_pkg::*;
#(
    parameter int                     NUM_CMDS  = 3,
    parameter logic [NUM_CMDS*48-1:0] CMD_TAGS  = {RATE_TAG, SLOW_TAG, TRIG_TAG},
    parameter int                     CNT_WIDTH = 16,
    localparam int                    ID_W      = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          RvviAxiRdata,
    input  logic [3:0]           RvviAxiRstrb,
    input  logic                 RvviAxiRlast,
    input  logic                 RvviAxiRvalid,
    input  logic [47:0]          ExpDstMac,
    input  logic [47:0]          ExpSrcMac,
    input  logic [15:0]          EthType,
    output logic                 CmdValid,
    output logic [ID_W-1:0]      CmdId,
    output logic [31:0]          CmdArg,
    output logic [CNT_WIDTH-1:0] FrameCount,
    output logic [CNT_WIDTH-1:0] DropCount
);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       tag_lo_q, tag_lo_d;
    logic [ID_W-1:0]   id_hold_q, id_hold_d;
    logic [31:0]       arg_hold_q, arg_hold_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [ID_W-1:0]   cmd_id_q, cmd_id_d;
    logic [31:0]       cmd_arg_q, cmd_arg_d;
    logic              commit, drop;

    logic [15:0]       tag_lo_sel;
    hdr_words_t        exp_words;
    logic [47:0]       cur_tag;
    logic              hdr_match, strb_ok, tag_hit;
    logic [ID_W-1:0]   tag_id;

    // In HDR the W3 tag half is taken from the beat itself so a full-word compare
    // checks only EthType; in TAG the stored half completes the tag.
    assign tag_lo_sel = (state_q == ST_TAG) ? tag_lo_q : RvviAxiRdata[31:16];
    assign exp_words  = pack_hdr_words(ExpDstMac, ExpSrcMac, EthType, {RvviAxiRdata, tag_lo_sel});
    assign cur_tag    = {exp_words[TAG_W4], exp_words[HDR_W3][31:16]};
    assign strb_ok    = (RvviAxiRstrb == 4'hF);

    always_comb begin
        case (idx_q)
            2'd0:    hdr_match = (RvviAxiRdata == exp_words[HDR_W0]);
            2'd1:    hdr_match = (RvviAxiRdata == exp_words[HDR_W1]);
            2'd2:    hdr_match = (RvviAxiRdata == exp_words[HDR_W2]);
            default: hdr_match = (RvviAxiRdata == exp_words[HDR_W3]);
        endcase
    end

    host_cmd_tagmatch #(
        .NUM_CMDS (NUM_CMDS),
        .CMD_TAGS (CMD_TAGS),
        .ID_W     (ID_W)
    ) u_tagmatch (
        .tag (cur_tag),
        .hit (tag_hit),
        .id  (tag_id)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tag_lo_d   = tag_lo_q;
        id_hold_d  = id_hold_q;
        arg_hold_d = arg_hold_q;
        commit     = 1'b0;
        drop       = 1'b0;
        if (RvviAxiRvalid) begin
            case (state_q)
                ST_HDR: begin
                    if (!strb_ok || !hdr_match || RvviAxiRlast) begin
                        idx_d = 2'd0;
                        if (RvviAxiRlast) drop    = 1'b1;
                        else              state_d = ST_DISCARD;
                    end else if (idx_q == 2'd3) begin
                        idx_d    = 2'd0;
                        tag_lo_d = RvviAxiRdata[31:16];
                        state_d  = ST_TAG;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                ST_TAG: begin
                    if (RvviAxiRlast) begin
                        drop    = 1'b1;
                        state_d = ST_HDR;
                    end else if (!strb_ok || !tag_hit) begin
                        state_d = ST_DISCARD;
                    end else begin
                        id_hold_d = tag_id;
                        state_d   = ST_ARG;
                    end
                end
                ST_ARG: begin
                    if (!strb_ok) begin
                        if (RvviAxiRlast) begin
                            drop    = 1'b1;
                            state_d = ST_HDR;
                        end else begin
                            state_d = ST_DISCARD;
                        end
                    end else begin
                        arg_hold_d = RvviAxiRdata;
                        if (RvviAxiRlast) begin
                            commit  = 1'b1;
                            state_d = ST_HDR;
                        end else begin
                            state_d = ST_WAITLAST;
                        end
                    end
                end
                ST_WAITLAST: begin
                    if (RvviAxiRlast) begin
                        commit  = 1'b1;
                        state_d = ST_HDR;
                    end
                end
                ST_DISCARD: begin
                    if (RvviAxiRlast) begin
                        drop    = 1'b1;
                        state_d = ST_HDR;
                    end
                end
                default: begin
                    state_d = ST_HDR;
                    idx_d   = 2'd0;
                end
            endcase
        end
        cmd_valid_d = commit;
        cmd_id_d    = commit ? id_hold_d  : cmd_id_q;
        cmd_arg_d   = commit ? arg_hold_d : cmd_arg_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HDR;
            idx_q       <= 2'd0;
            tag_lo_q    <= '0;
            id_hold_q   <= '0;
            arg_hold_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_id_q    <= '0;
            cmd_arg_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tag_lo_q    <= tag_lo_d;
            id_hold_q   <= id_hold_d;
            arg_hold_q  <= arg_hold_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_id_q    <= cmd_id_d;
            cmd_arg_q   <= cmd_arg_d;
        end
    end

    assign CmdValid = cmd_valid_q;
    assign CmdId    = cmd_id_q;
    assign CmdArg   = cmd_arg_q;

`ifdef HOSTCMD_STATS_EN
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    // Saturating counters: stick at all-ones rather than wrap.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (commit && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + 1'b1;
        if (drop && (drop_cnt_q != '1))    drop_cnt_d  = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign FrameCount = frame_cnt_q;
    assign DropCount  = drop_cnt_q;
`else
    assign FrameCount = '0;
    assign DropCount  = '0;
`endif

endmodule
